// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
//   Bundles the EX/MEM control and data inputs of the memory stage with its
//   MEM/WB and hazard/branch outputs.
//   master : EX/MEM side. Drives the *_in signals and observes the stage outputs.
//   slave  : the memory stage itself.
//   Signals:
//     result_in, store_data_in, pc_target_in [63:0] : EX/MEM datapath
//     rd_in [4:0], zero_in, branch_in, mem_read_in, mem_write_in,
//     mem_to_reg_in, reg_write_in                    : EX/MEM control
//     pcsrc, branch_target[63:0]                     : branch resolution to IF
//     mem_stall                                      : freeze request to hazard unit
//     read_data_out, alu_result_out [63:0], rd_out [4:0],
//     mem_to_reg_out, reg_write_out                  : MEM/WB register
//     wb_data [63:0]                                 : selected write-back value
//     misalign_err                                   : sticky misalignment flag
interface mem_wb_stage_if;
  logic [63:0] result_in;
  logic [63:0] store_data_in;
  logic [63:0] pc_target_in;
  logic [4:0]  rd_in;
  logic        zero_in;
  logic        branch_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        mem_to_reg_in;
  logic        reg_write_in;

  logic        pcsrc;
  logic [63:0] branch_target;
  logic        mem_stall;
  logic [63:0] read_data_out;
  logic [63:0] alu_result_out;
  logic [4:0]  rd_out;
  logic        mem_to_reg_out;
  logic        reg_write_out;
  logic [63:0] wb_data;
  logic        misalign_err;

  modport master (
    output result_in, store_data_in, pc_target_in, rd_in, zero_in, branch_in,
           mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in,
    input  pcsrc, branch_target, mem_stall, read_data_out, alu_result_out,
           rd_out, mem_to_reg_out, reg_write_out, wb_data, misalign_err
  );

  modport slave (
    input  result_in, store_data_in, pc_target_in, rd_in, zero_in, branch_in,
           mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in,
    output pcsrc, branch_target, mem_stall, read_data_out, alu_result_out,
           rd_out, mem_to_reg_out, reg_write_out, wb_data, misalign_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory-access stage of the 64-bit pipeline: resolves branches, performs
//   multi-cycle doubleword loads/stores against a local data memory, requests
//   a pipeline freeze while an access is in flight, and holds the MEM/WB
//   register that feeds write-back and forwarding.
//   Parameters:
//     DEPTH       : data memory size in doublewords (power of two)
//     MEM_LATENCY : cycles per load/store (1..15)
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high
//     bus   : mem_wb_stage_if.slave (EX/MEM inputs, MEM/WB and control outputs)
//   Build option:
//     MEM_MISALIGN_CHECK_EN : when defined, memory ops with result_in[2:0]!=0
//       suppress the store, load zero, and set the sticky misalign_err flag.
module mem_wb_stage #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic          clk,
  input logic          reset,
  mem_wb_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     mem_q [DEPTH];

  logic [63:0]     read_data_q, alu_result_q;
  logic [4:0]      rd_q;
  logic            mem_to_reg_q, reg_write_q;

  logic [AW-1:0]   idx;
  logic            mem_op;
  logic            stall;
  logic            complete;
  logic            misaligned;

  // Upper address bits are dropped, so addresses wrap modulo DEPTH*8 bytes.
  assign idx      = bus.result_in[AW+2:3];
  assign mem_op   = bus.mem_read_in | bus.mem_write_in;
  assign complete = mem_op & ~stall;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = mem_op & (bus.result_in[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && (MEM_LATENCY > 1)) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = CW'(MEM_LATENCY - 1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        // cnt==1 is the completion cycle: stall drops and the op retires.
        if (cnt_q > CW'(1)) begin
          stall = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stores commit only at the completion edge, so a reset during the access
  // leaves memory untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (complete && bus.mem_write_in && !misaligned) begin
      mem_q[idx] <= bus.store_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      if (stall) begin
        rd_q         <= '0;
        mem_to_reg_q <= 1'b0;
        reg_write_q  <= 1'b0;
      end else begin
        alu_result_q <= bus.result_in;
        rd_q         <= bus.rd_in;
        mem_to_reg_q <= bus.mem_to_reg_in;
        reg_write_q  <= bus.reg_write_in;
      end
      // Read-modify-write ops capture the pre-write contents here.
      if (complete && bus.mem_read_in) begin
        read_data_q <= misaligned ? '0 : mem_q[idx];
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (complete && misaligned) begin
      misalign_q <= 1'b1;
    end
  end

  assign bus.misalign_err = misalign_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.mem_stall      = stall;
  assign bus.pcsrc          = bus.branch_in & bus.zero_in & ~stall;
  assign bus.branch_target  = bus.pc_target_in;
  assign bus.read_data_out  = read_data_q;
  assign bus.alu_result_out = alu_result_q;
  assign bus.rd_out         = rd_q;
  assign bus.mem_to_reg_out = mem_to_reg_q;
  assign bus.reg_write_out  = reg_write_q;
  assign bus.wb_data        = mem_to_reg_q ? read_data_q : alu_result_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_if ia ();
  mem_wb_stage_if ib ();

  mem_wb_stage #(.DEPTH(64), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave)
  );
  mem_wb_stage #(.DEPTH(64), .MEM_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave)
  );

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
  } wb_t;

  int n_chk = 0;
  int n_fail = 0;

  wb_t         sbq[$];
  logic [63:0] mem_m [2][64];
  logic [63:0] exp_rd [2];
  logic        mis_m [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++) mem_m[f][i] = '0;
      exp_rd[f] = '0;
      mis_m[f]  = 1'b0;
    end
    sbq.delete();
  endtask

  task automatic drive(input bit f, input logic [63:0] res, sd, pct,
                       input logic [4:0] rd, input logic zr, br, mr, mw, m2r, rw);
    if (!f) begin
      ia.result_in = res; ia.store_data_in = sd; ia.pc_target_in = pct;
      ia.rd_in = rd; ia.zero_in = zr; ia.branch_in = br; ia.mem_read_in = mr;
      ia.mem_write_in = mw; ia.mem_to_reg_in = m2r; ia.reg_write_in = rw;
    end else begin
      ib.result_in = res; ib.store_data_in = sd; ib.pc_target_in = pct;
      ib.rd_in = rd; ib.zero_in = zr; ib.branch_in = br; ib.mem_read_in = mr;
      ib.mem_write_in = mw; ib.mem_to_reg_in = m2r; ib.reg_write_in = rw;
    end
  endtask

  task automatic sample(input bit f, output wb_t o, output logic stall, pcsrc, mis,
                        output logic [63:0] bt, wb);
    if (!f) begin
      o = '{alu: ia.alu_result_out, rdata: ia.read_data_out, rd: ia.rd_out,
            m2r: ia.mem_to_reg_out, rw: ia.reg_write_out};
      stall = ia.mem_stall; pcsrc = ia.pcsrc; mis = ia.misalign_err;
      bt = ia.branch_target; wb = ia.wb_data;
    end else begin
      o = '{alu: ib.alu_result_out, rdata: ib.read_data_out, rd: ib.rd_out,
            m2r: ib.mem_to_reg_out, rw: ib.reg_write_out};
      stall = ib.mem_stall; pcsrc = ib.pcsrc; mis = ib.misalign_err;
      bt = ib.branch_target; wb = ib.wb_data;
    end
  endtask

  task automatic check_zero(input bit f, input string tag);
    wb_t o; logic st, pc, mi; logic [63:0] bt, wb;
    sample(f, o, st, pc, mi, bt, wb);
    chk({tag, ".alu"}, o.alu, 64'h0);
    chk({tag, ".rdata"}, o.rdata, 64'h0);
    chk({tag, ".rd"}, 64'(o.rd), 64'h0);
    chk({tag, ".rw"}, 64'(o.rw), 64'h0);
    chk({tag, ".m2r"}, 64'(o.m2r), 64'h0);
    chk({tag, ".wb"}, wb, 64'h0);
    chk({tag, ".stall"}, 64'(st), 64'h0);
    chk({tag, ".mis"}, 64'(mi), 64'h0);
  endtask

  // Starts just after a rising edge; returns just after the op's final edge.
  task automatic op(input bit f, input string tag, input logic [63:0] addr, sd, pct,
                    input logic [4:0] rd, input logic zr, br, mr, mw, m2r, rw);
    wb_t e, o;
    logic st, pc, mi;
    logic [63:0] bt, wb;
    logic [5:0] idx;
    bit memop, mis;
    int lat;
    memop = mr | mw;
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = memop && (addr[2:0] != 3'b000);
`endif
    idx = addr[8:3];
    lat = (memop && !f) ? 2 : 1;
    drive(f, addr, sd, pct, rd, zr, br, mr, mw, m2r, rw);
    e.alu = addr; e.rd = rd; e.m2r = m2r; e.rw = rw;
    if (mr) exp_rd[f] = mis ? 64'h0 : mem_m[f][idx];
    e.rdata = exp_rd[f];
    if (mw && !mis) mem_m[f][idx] = sd;
    if (mis) mis_m[f] = 1'b1;
    sbq.push_back(e);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      sample(f, o, st, pc, mi, bt, wb);
      chk({tag, ".stall"}, 64'(st), 64'(k < lat - 1));
      chk({tag, ".pcsrc"}, 64'(pc), 64'(br & zr & (k == lat - 1)));
      chk({tag, ".btarget"}, bt, pct);
      @(posedge clk);
      #1;
      if (k < lat - 1) begin
        sample(f, o, st, pc, mi, bt, wb);
        chk({tag, ".bubble_rw"}, 64'(o.rw), 64'h0);
        chk({tag, ".bubble_rd"}, 64'(o.rd), 64'h0);
        chk({tag, ".bubble_m2r"}, 64'(o.m2r), 64'h0);
      end
    end
    sample(f, o, st, pc, mi, bt, wb);
    e = sbq.pop_front();
    chk({tag, ".alu"}, o.alu, e.alu);
    chk({tag, ".rdata"}, o.rdata, e.rdata);
    chk({tag, ".rd"}, 64'(o.rd), 64'(e.rd));
    chk({tag, ".rw"}, 64'(o.rw), 64'(e.rw));
    chk({tag, ".m2r"}, 64'(o.m2r), 64'(e.m2r));
    chk({tag, ".wb"}, wb, e.m2r ? e.rdata : e.alu);
    chk({tag, ".mis"}, 64'(mi), 64'(mis_m[f]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    drive(1, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_zero(0, "rst_a");
    check_zero(1, "rst_b");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    drive(1, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset in the 2nd cycle of a store to 0x10: store must not commit.
    drive(0, 64'h10, 64'h1234_5678_9ABC_DEF0, '0, 5'd0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("rst_mid.stall1", 64'(ia.mem_stall), 64'h1);
    @(posedge clk);
    #1;
    do_reset();
    op(0, "rst_mid.load", 64'h10, '0, '0, 5'd3, 0, 0, 1, 0, 1, 1);

    // Store then load of the same doubleword.
    op(0, "st18", 64'h18, 64'hDEADBEEF_00000001, '0, 5'd0, 0, 0, 0, 1, 0, 0);
    op(0, "ld18", 64'h18, '0, '0, 5'd5, 0, 0, 1, 0, 1, 1);
    op(0, "alu7", 64'h0000_0000_0000_0777, '0, '0, 5'd7, 0, 0, 0, 0, 0, 1);

    // Branch resolution.
    op(0, "br_taken", 64'h0, '0, 64'h40, 5'd0, 1, 1, 0, 0, 0, 0);
    op(0, "br_not", 64'h0, '0, 64'h40, 5'd0, 0, 1, 0, 0, 0, 0);

    // Address wrap-around.
    op(0, "st200", 64'h200, 64'h55, '0, 5'd0, 0, 0, 0, 1, 0, 0);
    op(0, "ld0", 64'h0, '0, '0, 5'd9, 0, 0, 1, 0, 1, 1);

    // Combined read+write returns the old contents.
    op(0, "rmw18", 64'h18, 64'h1111_2222_3333_4444, '0, 5'd4, 0, 0, 1, 1, 1, 1);
    op(0, "ld18b", 64'h18, '0, '0, 5'd6, 0, 0, 1, 0, 1, 1);

    // Misaligned store to 0x0C, then read back doubleword 1.
    op(0, "st0c", 64'h0C, 64'h77, '0, 5'd0, 0, 0, 0, 1, 0, 0);
    op(0, "alu_after_mis", 64'h123, '0, '0, 5'd2, 0, 0, 0, 0, 0, 1);
    op(0, "ld08", 64'h08, '0, '0, 5'd8, 0, 0, 1, 0, 1, 1);
    do_reset();

    // Single-cycle latency instance: alternating ALU, load, store.
    op(1, "f_alu", 64'hABC, '0, '0, 5'd1, 0, 0, 0, 0, 0, 1);
    op(1, "f_ld_empty", 64'h18, '0, '0, 5'd2, 0, 0, 1, 0, 1, 1);
    op(1, "f_st", 64'h18, 64'hCAFE_F00D_0000_0042, '0, 5'd0, 0, 0, 0, 1, 0, 0);
    op(1, "f_alu2", 64'hDEF, '0, '0, 5'd3, 0, 0, 0, 0, 0, 1);
    op(1, "f_ld", 64'h18, '0, '0, 5'd4, 0, 0, 1, 0, 1, 1);
    op(1, "f_br", 64'h0, '0, 64'h80, 5'd0, 1, 1, 0, 0, 0, 0);
    drive(1, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the 64-bit pipelined processor. It sits between the EX/MEM register and the write-back stage. It resolves branches, performs multi-cycle doubleword loads and stores against a local data memory, and raises a stall to the hazard unit while an access is in flight. It also contains the MEM/WB pipeline register and drives the write-back value used by the forwarding unit.

## Interface
Parameters:
- DEPTH, 64: data memory size in 64-bit doublewords; power of two.
- MEM_LATENCY, 2: cycles per load/store, range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- result_in  in  64  ALU result from EX/MEM; the byte address for memory ops.
- store_data_in  in  64  store data from EX/MEM.
- pc_target_in  in  64  branch target from EX/MEM.
- rd_in  in  5  destination register.
- zero_in, branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in  in  1 each  EX/MEM control bits.
- pcsrc  out  1  taken-branch select to IF.
- branch_target  out  64  equals pc_target_in.
- mem_stall  out  1  freeze request to the hazard unit.
- read_data_out, alu_result_out  out  64  MEM/WB register.
- rd_out  out  5  MEM/WB register.
- mem_to_reg_out, reg_write_out  out  1  MEM/WB register.
- wb_data  out  64  mem_to_reg_out ? read_data_out : alu_result_out.
- misalign_err  out  1  sticky misalignment flag (see Configuration).

## Operation
- A memory op is a cycle with mem_read_in or mem_write_in set. If both are set, the op is a store, and read_data_out captures the contents before the write.
- Memory index is result_in[$clog2(DEPTH)+2:3]. Upper address bits are ignored, so addresses wrap modulo DEPTH*8 bytes.
- FSM states:
  - IDLE: on a memory op with MEM_LATENCY>1, go to BUSY and load cnt with MEM_LATENCY-1.
  - BUSY: decrement cnt each cycle. When cnt==1, return to IDLE.
- Counter cnt is $clog2(MEM_LATENCY+1) bits wide.
- mem_stall is combinational. It is 1 in IDLE with a memory op and MEM_LATENCY>1. It is 1 in BUSY while cnt>1. It is 0 otherwise.
- Completion cycle: the cycle in which mem_stall is 0 and a memory op is present. Only at its closing edge does a store commit and read_data_out load mem[index].
- The hazard unit holds all EX/MEM inputs stable while mem_stall is 1.
- MEM/WB update:
  - While mem_stall is 1, insert a bubble at each edge: reg_write_out=0, mem_to_reg_out=0, rd_out=0. read_data_out and alu_result_out hold.
  - Otherwise, load alu_result_out=result_in, rd_out, mem_to_reg_out and reg_write_out from inputs.
  - read_data_out loads only on a load completion and holds otherwise.
- Branch: pcsrc = branch_in & zero_in & ~mem_stall, combinational, same cycle as the inputs.

## Timing
- Reset values: all outputs 0, FSM IDLE, cnt 0, every memory word 0, misalign_err 0. Asserting reset mid-access aborts it; a pending store never commits.
- Non-memory op: 1 cycle; the MEM/WB outputs reflect it after the next edge.
- Memory op: occupies exactly MEM_LATENCY cycles, with mem_stall high for the first MEM_LATENCY-1 of them. The result is visible after the final edge.
- MEM_LATENCY=1: mem_stall is never asserted, and the FSM stays in IDLE.
- Back-to-back memory ops: the second op's first cycle follows the completion cycle directly, with no idle gap.
- Load then dependent instruction: wb_data is valid from the edge after completion, for MEM/WB forwarding.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - A memory op with result_in[2:0]!=0 still takes the full latency, but the store is suppressed and read_data_out loads 0.
  - misalign_err is set at the completion edge and stays 1 until reset.
- Not defined: result_in[2:0] is ignored, and misalign_err is tied to 0.

## Test plan
- Reset mid-access: reset in the 2nd cycle of a store to 0x10 -> mem[2] stays 0, all outputs 0, mem_stall 0.
- Store then load, MEM_LATENCY=2: store 0xDEADBEEF_00000001 to 0x18, then load 0x18 with rd=5 -> each op asserts mem_stall for 1 cycle; after the load completes, read_data_out and wb_data are 0xDEADBEEF_00000001, rd_out=5, reg_write_out=1, and the bubble cycles show reg_write_out=0.
- Branch: branch_in=1, zero_in=1, pc_target_in=0x40 -> pcsrc=1 and branch_target=0x40 in the same cycle; with zero_in=0 -> pcsrc=0.
- Wrap-around, DEPTH=64: store 0x55 to byte address 0x200 -> a load from 0x0 returns 0x55.
- MEM_LATENCY=1: alternating ALU op, load, store -> mem_stall stays 0, and each result appears one edge later.
- With MEM_MISALIGN_CHECK_EN, store to 0x0C -> mem[1] unchanged and misalign_err=1 until reset. Without the macro, the same store writes mem[1].
